// File: rtl/axis_rr_arbiter_32.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter_32
//   Packet-granular round-robin arbiter that merges N_SRC 32-bit AXI4-Stream
//   sources onto one fully registered AXI4-Stream output.
//
//   An IDLE cycle picks the first requesting source at or above rr_ptr,
//   wrapping around. The grant then holds in BUSY until that source's tlast
//   beat is accepted. rr_ptr then moves to the source after the winner.
//
// Ports
//   aclk, areset         : clock (rising edge), asynchronous active-high reset
//   s_axis_t*            : per-source stream inputs (arrays / vectors of N_SRC)
//   s_axis_tready        : per-source ready, only the granted source can be 1
//   m_axis_t*            : registered output stream
//   m_axis_tready        : downstream ready
//   grant_valid          : a packet grant is active
//   grant_id             : current or most recently granted source index
//   pkt_cnt              : packets completed (tlast accepted), wraps at 2^32
// ---------------------------------------------------------------------------
module axis_rr_arbiter_32 #(
    parameter int N_SRC   = 4,
    parameter int ID_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [31:0]        s_axis_tdata [N_SRC],
    input  logic [3:0]         s_axis_tkeep [N_SRC],
    input  logic [N_SRC-1:0]   s_axis_tlast,
    input  logic [N_SRC-1:0]   s_axis_tvalid,
    output logic [N_SRC-1:0]   s_axis_tready,
    output logic [31:0]        m_axis_tdata,
    output logic [3:0]         m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               grant_valid,
    output logic [ID_BITS-1:0] grant_id,
    output logic [31:0]        pkt_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ID_BITS-1:0] rr_ptr_r;
    logic [ID_BITS-1:0] grant_id_r;
    logic               grant_valid_r;
    logic [31:0]        pkt_cnt_r;
    logic [31:0]        m_tdata_r;
    logic [3:0]         m_tkeep_r;
    logic               m_tlast_r;
    logic               m_tvalid_r;

    logic               out_ready_s;
    logic               any_req_s;
    logic [ID_BITS-1:0] pick_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               grant_s;
    logic               accept_s;
    logic               done_s;

    // Lowest requesting index >= ptr wins; if none, the lowest index below
    // ptr wins, which is the modulo-N upward search from ptr.
    function automatic logic [ID_BITS-1:0] rr_pick(
        input logic [N_SRC-1:0]   req,
        input logic [ID_BITS-1:0] ptr
    );
        logic [ID_BITS-1:0] hi_idx;
        logic [ID_BITS-1:0] lo_idx;
        logic               hi_hit;
        hi_idx = {ID_BITS{1'b0}};
        lo_idx = {ID_BITS{1'b0}};
        hi_hit = 1'b0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (ID_BITS'(j) >= ptr) begin
                    hi_idx = ID_BITS'(j);
                    hi_hit = 1'b1;
                end else begin
                    lo_idx = ID_BITS'(j);
                end
            end
        end
        return hi_hit ? hi_idx : lo_idx;
    endfunction

    // Wrap-around increment used to advance rr_ptr past the finished source.
    function automatic logic [ID_BITS-1:0] next_idx(input logic [ID_BITS-1:0] idx);
        logic [ID_BITS-1:0] nxt;
        if (idx == ID_BITS'(N_SRC - 1)) begin
            nxt = {ID_BITS{1'b0}};
        end else begin
            nxt = idx + ID_BITS'(1);
        end
        return nxt;
    endfunction

    assign out_ready_s = !m_tvalid_r || m_axis_tready;
    assign any_req_s   = |s_axis_tvalid;
    assign pick_s      = rr_pick(s_axis_tvalid, rr_ptr_r);
    assign sel_valid_s = s_axis_tvalid[grant_id_r];
    assign sel_last_s  = s_axis_tlast[grant_id_r];

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus the grant / beat-accept / packet-done strobes.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (sel_valid_s && out_ready_s) begin
                    accept_s = 1'b1;
                    if (sel_last_s) begin
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Only the granted source sees ready, and only while BUSY. Because
    // state_r resets asynchronously, every ready is 0 while areset is high.
    always_comb begin
        s_axis_tready = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if ((state_r == BUSY) && (grant_id_r == ID_BITS'(i))) begin
                s_axis_tready[i] = out_ready_s;
            end else begin
                s_axis_tready[i] = 1'b0;
            end
        end
    end

    // Grant bookkeeping: grant_id, grant_valid, rr_ptr and packet counter.
    // grant_id holds after the packet ends so it reports the last winner.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr_r      <= {ID_BITS{1'b0}};
            grant_id_r    <= {ID_BITS{1'b0}};
            grant_valid_r <= 1'b0;
            pkt_cnt_r     <= 32'd0;
        end else if (grant_s) begin
            grant_id_r    <= pick_s;
            grant_valid_r <= 1'b1;
        end else if (done_s) begin
            grant_valid_r <= 1'b0;
            rr_ptr_r      <= next_idx(grant_id_r);
            pkt_cnt_r     <= pkt_cnt_r + 32'd1;
        end else begin
            grant_valid_r <= grant_valid_r;
        end
    end

    // Output register: load on accept, drop valid once consumed, otherwise
    // hold so the beat stays stable under backpressure.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tdata_r  <= 32'd0;
            m_tkeep_r  <= 4'd0;
            m_tlast_r  <= 1'b0;
            m_tvalid_r <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= s_axis_tdata[grant_id_r];
            m_tkeep_r  <= s_axis_tkeep[grant_id_r];
            m_tlast_r  <= sel_last_s;
            m_tvalid_r <= 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_r <= 1'b0;
        end else begin
            m_tvalid_r <= m_tvalid_r;
        end
    end

    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tkeep  = m_tkeep_r;
    assign m_axis_tlast  = m_tlast_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign grant_valid   = grant_valid_r;
    assign grant_id      = grant_id_r;
    assign pkt_cnt       = pkt_cnt_r;

endmodule

// File: tb/tb_axis_rr_arbiter_32.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter_32
//   Directed scenarios plus a randomized phase. The bench models the arbiter
//   at packet level. Each source holds a list of whole packets. When a grant
//   happens, the chosen source's next whole packet is appended to the
//   expected output stream. Every cycle the bench checks the outputs against
//   that model: readies, output register contents, grant_valid, grant_id and
//   pkt_cnt.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter_32;

    localparam int N = 4;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [31:0]  s_tdata [N];
    logic [3:0]   s_tkeep [N];
    logic [N-1:0] s_tlast = '0;
    logic [N-1:0] s_tvalid = '0;
    logic [N-1:0] s_tready;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [31:0]  pkt_cnt;

    int checks = 0;
    int errors = 0;

    axis_rr_arbiter_32 #(.N_SRC(N)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .pkt_cnt       (pkt_cnt)
    );

    initial forever #5 aclk = ~aclk;

    // reference model state
    int          mdl_ptr;
    int          mdl_g;
    bit          mdl_busy;
    bit          mdl_mv;
    logic [31:0] mdl_cnt;
    logic [36:0] mdl_out;
    logic [36:0] exp_out [$];

    // source stimulus: beats {last, keep, data}
    logic [36:0] sq [N][$];
    int          spos [N];
    int          gpos [N];
    int          stall_pct [N];
    int          st_src, st_from, st_len;
    int          mr_pct, lo_from, lo_len;
    int          cyc;
    int          gq [$];
    bit          prev_gv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_ptr  = 0;
        mdl_g    = 0;
        mdl_busy = 1'b0;
        mdl_mv   = 1'b0;
        mdl_cnt  = 32'd0;
        mdl_out  = 37'd0;
        exp_out.delete();
        prev_gv  = 1'b0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            spos[i]      = 0;
            gpos[i]      = 0;
            stall_pct[i] = 0;
        end
        st_src  = -1;
        st_from = 0;
        st_len  = 0;
        mr_pct  = 100;
        lo_from = 0;
        lo_len  = 0;
        cyc     = 0;
        gq.delete();
    endtask

    task automatic add_pkt(input int s, input int len, input logic [31:0] base, input bit rnd_keep);
        logic [3:0] keep;
        for (int b = 0; b < len; b++) begin
            keep = rnd_keep ? 4'($urandom) : 4'hF;
            sq[s].push_back({(b == len - 1) ? 1'b1 : 1'b0, keep, base + 32'(b)});
        end
    endtask

    function automatic bit done_all();
        for (int i = 0; i < N; i++) begin
            if (spos[i] < sq[i].size()) return 1'b0;
        end
        return !mdl_busy && (exp_out.size() == 0);
    endfunction

    task automatic drive();
        bit have, stall;
        for (int i = 0; i < N; i++) begin
            have  = spos[i] < sq[i].size();
            stall = (int'($urandom_range(99)) < stall_pct[i]) ||
                    (i == st_src && cyc >= st_from && cyc < st_from + st_len);
            s_tvalid[i] = have && !stall;
            if (have) begin
                {s_tlast[i], s_tkeep[i], s_tdata[i]} = sq[i][spos[i]];
            end else begin
                {s_tlast[i], s_tkeep[i], s_tdata[i]} = 37'd0;
            end
        end
        m_tready = !(cyc >= lo_from && cyc < lo_from + lo_len) &&
                   (int'($urandom_range(99)) < mr_pct);
    endtask

    // One clock cycle: drive after the falling edge, check readies before the
    // rising edge, advance the model, check registered outputs after it.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        logic [36:0]  b;
        bit           ordy, acc, was_busy;
        int           pick, idx;
        drive();
        #1;
        ordy    = !mdl_mv || m_tready;
        exp_rdy = '0;
        if (mdl_busy && ordy) exp_rdy[mdl_g] = 1'b1;
        chk("s_tready", 64'(s_tready), 64'(exp_rdy));
        was_busy = mdl_busy;
        acc      = mdl_busy && s_tvalid[mdl_g] && ordy;
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) spos[i]++;
        end
        if (acc) begin
            if (exp_out.size() == 0) begin
                chk("exp_empty", 64'd1, 64'd0);
                mdl_out = 37'd0;
            end else begin
                mdl_out = exp_out.pop_front();
            end
            mdl_mv = 1'b1;
            if (mdl_out[36]) begin
                mdl_busy = 1'b0;
                mdl_ptr  = (mdl_g + 1) % N;
                mdl_cnt  = mdl_cnt + 32'd1;
            end
        end else if (m_tready) begin
            mdl_mv = 1'b0;
        end
        if (!was_busy) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mdl_ptr + k) % N;
                if (pick < 0 && s_tvalid[idx]) pick = idx;
            end
            if (pick >= 0) begin
                mdl_g    = pick;
                mdl_busy = 1'b1;
                do begin
                    b = sq[pick][gpos[pick]];
                    gpos[pick]++;
                    exp_out.push_back(b);
                end while (!b[36] && gpos[pick] < sq[pick].size());
            end
        end
        @(posedge aclk);
        #1;
        chk("grant_valid", 64'(grant_valid), 64'(mdl_busy));
        chk("grant_id", 64'(grant_id), 64'(mdl_g));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(mdl_cnt));
        chk("m_tvalid", 64'(m_tvalid), 64'(mdl_mv));
        if (mdl_mv) chk("m_beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(mdl_out));
        if (grant_valid && !prev_gv) gq.push_back(int'(grant_id));
        prev_gv = grant_valid;
        cyc++;
        @(negedge aclk);
    endtask

    task automatic run(input int max_cyc);
        int n;
        n = 0;
        while (!done_all() && n < max_cyc) begin
            tick();
            n++;
        end
        chk("run_timeout", 64'(done_all()), 64'd1);
        tick();
    endtask

    // Assert reset asynchronously (no clock edge in between) and check that
    // every output is already at its reset value.
    task automatic do_reset();
        areset = 1'b1;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        @(posedge aclk);
        #1;
        chk("rst_s_tready_hold", 64'(s_tready), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        clear_src();
    endtask

    initial begin
        int exp_order [5];
        int got;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            s_tdata[i] = 32'd0;
            s_tkeep[i] = 4'd0;
        end
        model_reset();
        clear_src();
        @(negedge aclk);
        do_reset();

        // single source, 3 beats, output always ready
        add_pkt(0, 3, 32'h000000A0, 1'b0);
        run(50);
        chk("s1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("s1_grant_id", 64'(grant_id), 64'd0);

        // all four sources request, 2-beat packets
        do_reset();
        add_pkt(0, 2, 32'h00000100, 1'b0);
        add_pkt(0, 2, 32'h00000110, 1'b0);
        add_pkt(1, 2, 32'h00000200, 1'b0);
        add_pkt(2, 2, 32'h00000300, 1'b0);
        add_pkt(3, 2, 32'h00000400, 1'b0);
        run(100);
        for (int k = 0; k < 5; k++) begin
            got = (gq.size() > k) ? gq[k] : -1;
            chk($sformatf("s2_order%0d", k), 64'(got), 64'(exp_order[k]));
        end
        chk("s2_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // backpressure: downstream not ready for 5 cycles mid-packet
        clear_src();
        add_pkt(1, 4, 32'h000000B0, 1'b1);
        lo_from = 3;
        lo_len  = 5;
        run(50);
        chk("s3_pkt_cnt", 64'(pkt_cnt), 64'd6);

        // granted src2 stalls 3 cycles while src1 waits
        clear_src();
        add_pkt(2, 4, 32'h000000C0, 1'b0);
        add_pkt(1, 2, 32'h000000D0, 1'b0);
        st_src  = 2;
        st_from = 3;
        st_len  = 3;
        run(60);
        got = (gq.size() > 0) ? gq[0] : -1;
        chk("s4_first", 64'(got), 64'd2);
        got = (gq.size() > 1) ? gq[1] : -1;
        chk("s4_second", 64'(got), 64'd1);

        // reset during the 2nd beat of a 4-beat packet, then src3 alone
        clear_src();
        add_pkt(1, 4, 32'h000000E0, 1'b0);
        tick();
        tick();
        tick();
        chk("s5_mid_valid", 64'(m_tvalid), 64'd1);
        do_reset();
        add_pkt(3, 2, 32'h000000F0, 1'b0);
        run(30);
        got = (gq.size() > 0) ? gq[0] : -1;
        chk("s5_grant3", 64'(got), 64'd3);

        // counter wrap on a single-beat packet
        clear_src();
        force dut.pkt_cnt_r = 32'hFFFFFFFF;
        #1;
        release dut.pkt_cnt_r;
        mdl_cnt = 32'hFFFFFFFF;
        add_pkt(0, 1, 32'h00000011, 1'b0);
        run(20);
        chk("s6_wrap", 64'(pkt_cnt), 64'd0);

        // randomized traffic, stalls and backpressure
        clear_src();
        for (int i = 0; i < N; i++) begin
            stall_pct[i] = 25;
            for (int p = 0; p < 3; p++) begin
                add_pkt(i, int'($urandom_range(1, 4)), $urandom, 1'b1);
            end
        end
        mr_pct = 70;
        run(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
